// File: rtl/chi_rx_link.sv
// Receive-side CHI link-layer stage: link activation handshake, L-credit issue,
// credit-backed flit FIFO and LCrdReturn consumption for one flit channel.
module chi_rx_link #(
  parameter int unsigned NUM_CRD      = 4,
  parameter int unsigned FLIT_W       = 128,
  parameter int unsigned OPC_LSB      = 0,
  parameter int unsigned OPC_W        = 7,
  parameter int unsigned LCRD_RET_OPC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RX_FLITPEND,
  input  logic              RX_FLITV,
  input  logic [FLIT_W-1:0] RX_FLIT,
  output logic              RX_LCRDV,
  input  logic              RX_LINKACTIVEREQ,
  output logic              RX_LINKACTIVEACK,
  output logic [FLIT_W-1:0] flit_out,
  output logic              flit_valid,
  input  logic              flit_ready,
  output logic [3:0]        crd_out,
  output logic [1:0]        link_state,
  output logic              ovf_err
);

  localparam int unsigned PTR_W = (NUM_CRD > 1) ? $clog2(NUM_CRD) : 1;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {
    ST_STOP     = 2'b00,
    ST_ACTIVATE = 2'b01,
    ST_RUN      = 2'b10,
    ST_DEACT    = 2'b11
  } state_t;

  state_t             state, state_n;
  logic [PTR_W-1:0]   rd_ptr, wr_ptr, rd_ptr_n, wr_ptr_n;
  logic [CNT_W-1:0]   fifo_count, fifo_count_n, crd_n;
  logic [FLIT_W-1:0]  mem [NUM_CRD];
  logic [FLIT_W-1:0]  head_n;
  logic [SUM_W-1:0]   crd_sum;
  logic               is_ret, full, pop, accept, push, drop, lcrdv_n;
  logic               unused_flitpend;

  assign unused_flitpend = RX_FLITPEND;
  assign link_state      = state;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_CRD - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state link FSM
  always_comb begin
    state_n = state;
    case (state)
      ST_STOP:     if (RX_LINKACTIVEREQ) state_n = ST_ACTIVATE;
      ST_ACTIVATE: state_n = ST_RUN;
      ST_RUN:      if (!RX_LINKACTIVEREQ) state_n = ST_DEACT;
      ST_DEACT:    if (crd_out == '0) state_n = ST_STOP;
      default:     state_n = ST_STOP;
    endcase
  end

  // Flit acceptance, credit accounting and FIFO next values
  always_comb begin
    is_ret       = RX_FLIT[OPC_LSB +: OPC_W] == OPC_W'(LCRD_RET_OPC);
    full         = fifo_count == CNT_W'(NUM_CRD);
    pop          = flit_valid && flit_ready;
    accept       = RX_FLITV && (crd_out != '0) && (is_ret || !full || pop);
    push         = accept && !is_ret;
    drop         = RX_FLITV && !accept;
    crd_n        = crd_out + CNT_W'(RX_LCRDV) - CNT_W'(accept);
    fifo_count_n = fifo_count + CNT_W'(push) - CNT_W'(pop);
    rd_ptr_n     = pop  ? ptr_inc(rd_ptr) : rd_ptr;
    wr_ptr_n     = push ? ptr_inc(wr_ptr) : wr_ptr;
    head_n       = flit_out;
    // A push landing on the new head slot bypasses the memory
    if (fifo_count_n != '0) begin
      head_n = (push && (rd_ptr_n == wr_ptr)) ? RX_FLIT : mem[rd_ptr_n];
    end
    crd_sum = SUM_W'(crd_out) + SUM_W'(fifo_count) + SUM_W'(RX_LCRDV);
    lcrdv_n = (state_n == ST_RUN) && (crd_sum < SUM_W'(NUM_CRD));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_STOP;
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      fifo_count       <= '0;
      crd_out          <= '0;
      RX_LCRDV         <= 1'b0;
      RX_LINKACTIVEACK <= 1'b0;
      flit_valid       <= 1'b0;
      flit_out         <= '0;
      ovf_err          <= 1'b0;
    end else begin
      state            <= state_n;
      rd_ptr           <= rd_ptr_n;
      wr_ptr           <= wr_ptr_n;
      fifo_count       <= fifo_count_n;
      crd_out          <= crd_n;
      RX_LCRDV         <= lcrdv_n;
      RX_LINKACTIVEACK <= state_n != ST_STOP;
      flit_valid       <= fifo_count_n != '0;
      flit_out         <= head_n;
      if (drop) ovf_err <= 1'b1;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= RX_FLIT;
  end

endmodule

// File: tb/tb_chi_rx_link.sv
// Self-checking bench for chi_rx_link: directed test-plan steps plus a random
// phase, all outputs compared each cycle against a queue-based reference model.
module tb_chi_rx_link;

  localparam int unsigned NUM_CRD = 4;
  localparam int unsigned FLIT_W  = 128;
  localparam int unsigned OPC_W   = 7;
  localparam logic [OPC_W-1:0] OPC_READ_SHARED = 7'h01;
  localparam logic [OPC_W-1:0] OPC_COMP_ACK    = 7'h14;

  logic              clk = 1'b0;
  logic              rst, flitpend, flitv, lcrdv, lareq, laack;
  logic              flit_valid, flit_ready, ovf_err;
  logic [FLIT_W-1:0] flit, flit_out;
  logic [3:0]        crd_out;
  logic [1:0]        link_state;

  always #5 clk = ~clk;

  chi_rx_link #(.NUM_CRD(NUM_CRD), .FLIT_W(FLIT_W), .OPC_LSB(0), .OPC_W(OPC_W),
                .LCRD_RET_OPC(0)) dut (
    .clk(clk), .rst(rst), .RX_FLITPEND(flitpend), .RX_FLITV(flitv), .RX_FLIT(flit),
    .RX_LCRDV(lcrdv), .RX_LINKACTIVEREQ(lareq), .RX_LINKACTIVEACK(laack),
    .flit_out(flit_out), .flit_valid(flit_valid), .flit_ready(flit_ready),
    .crd_out(crd_out), .link_state(link_state), .ovf_err(ovf_err)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: link state 0..3, outstanding credits, buffered flit queue
  int                m_state, m_crd;
  bit                m_lcrdv, m_ovf;
  logic [FLIT_W-1:0] q[$];

  int                pulses, stale;
  logic [FLIT_W-1:0] f;
  logic [FLIT_W-1:0] sent [4];
  bit                rv, rr;
  logic [OPC_W-1:0]  ropc;

  task automatic check(input string tag, input logic [FLIT_W-1:0] obs,
                       input logic [FLIT_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mk_flit(input logic [OPC_W-1:0] opc);
    logic [FLIT_W-1:0] r;
    for (int i = 0; i < FLIT_W / 32; i++) r[i*32 +: 32] = $urandom;
    r[OPC_W-1:0] = opc;
    return r;
  endfunction

  function automatic logic [OPC_W-1:0] rand_opc();
    return OPC_W'($urandom_range(1, 127));
  endfunction

  task automatic model_edge();
    int nxt;
    bit pop, acc, ret, nl;
    if (rst) begin
      m_state = 0; m_crd = 0; m_lcrdv = 0; m_ovf = 0;
      q.delete();
      return;
    end
    pop = (q.size() != 0) && flit_ready;
    ret = flitv && (flit[OPC_W-1:0] == '0);
    acc = flitv && (m_crd > 0);
    case (m_state)
      0:       nxt = lareq ? 1 : 0;
      1:       nxt = 2;
      2:       nxt = lareq ? 2 : 3;
      default: nxt = (m_crd == 0) ? 0 : 3;
    endcase
    nl = (nxt == 2) && (m_crd + q.size() + int'(m_lcrdv) < int'(NUM_CRD));
    m_crd = m_crd + int'(m_lcrdv) - int'(acc);
    if (flitv && !acc) m_ovf = 1;
    if (pop) void'(q.pop_front());
    if (acc && !ret) q.push_back(flit);
    m_state = nxt;
    m_lcrdv = nl;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"}, FLIT_W'(link_state), FLIT_W'(m_state));
    check({tag, ".ack"},   FLIT_W'(laack),      FLIT_W'(m_state != 0));
    check({tag, ".lcrdv"}, FLIT_W'(lcrdv),      FLIT_W'(m_lcrdv));
    check({tag, ".crd"},   FLIT_W'(crd_out),    FLIT_W'(m_crd));
    check({tag, ".valid"}, FLIT_W'(flit_valid), FLIT_W'(q.size() != 0));
    check({tag, ".ovf"},   FLIT_W'(ovf_err),    FLIT_W'(m_ovf));
    if (q.size() != 0) check({tag, ".flit"}, flit_out, q[0]);
  endtask

  task automatic step(input bit v, input logic [FLIT_W-1:0] fl, input bit rdy);
    flitv = v; flit = fl; flit_ready = rdy; flitpend = v;
    @(posedge clk);
    model_edge();
    #1;
    check_all("cyc");
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, rdy);
  endtask

  initial begin
    rst = 1'b1; lareq = 1'b0; flitv = 1'b0; flit = '0; flit_ready = 1'b0; flitpend = 1'b0;

    // Reset
    idle(2, 1'b0);
    check("rst.flit_out", flit_out, '0);
    check("rst.crd", FLIT_W'(crd_out), '0);
    check("rst.state", FLIT_W'(link_state), '0);
    rst = 1'b0;

    // Bring-up
    lareq = 1'b1;
    idle(1, 1'b0);
    check("up.activate", FLIT_W'(link_state), FLIT_W'(2'b01));
    check("up.ack", FLIT_W'(laack), FLIT_W'(1));
    idle(1, 1'b0);
    check("up.run", FLIT_W'(link_state), FLIT_W'(2'b10));
    pulses = int'(lcrdv);
    for (int i = 0; i < 6; i++) begin
      idle(1, 1'b0);
      pulses += int'(lcrdv);
    end
    check("up.pulses", FLIT_W'(pulses), FLIT_W'(4));
    check("up.crd", FLIT_W'(crd_out), FLIT_W'(4));

    // Back-pressure
    for (int i = 0; i < 4; i++) begin
      sent[i] = mk_flit(OPC_READ_SHARED);
      step(1'b1, sent[i], 1'b0);
    end
    check("bp.crd", FLIT_W'(crd_out), '0);
    check("bp.valid", FLIT_W'(flit_valid), FLIT_W'(1));
    check("bp.head", flit_out, sent[0]);
    check("bp.nolcrdv", FLIT_W'(lcrdv), '0);
    idle(1, 1'b1);
    check("bp.pop_head", flit_out, sent[1]);
    pulses = int'(lcrdv);
    for (int i = 0; i < 4; i++) begin
      idle(1, 1'b0);
      pulses += int'(lcrdv);
    end
    check("bp.one_pulse", FLIT_W'(pulses), FLIT_W'(1));
    for (int i = 1; i < 4; i++) begin
      check("bp.order", flit_out, sent[i]);
      idle(1, 1'b1);
    end
    check("bp.empty", FLIT_W'(flit_valid), '0);
    idle(6, 1'b1);
    check("bp.refill", FLIT_W'(crd_out), FLIT_W'(4));

    // Streaming
    for (int i = 0; i < 20; i++) begin
      f = mk_flit(rand_opc());
      step(1'b1, f, 1'b1);
      check("stream.out", flit_out, f);
      check("stream.valid", FLIT_W'(flit_valid), FLIT_W'(1));
    end
    idle(8, 1'b1);
    check("stream.crd", FLIT_W'(crd_out), FLIT_W'(4));
    check("stream.ovf", FLIT_W'(ovf_err), '0);

    // Deactivation with three credits outstanding
    lareq = 1'b0;
    step(1'b1, mk_flit(rand_opc()), 1'b1);
    check("deact.state", FLIT_W'(link_state), FLIT_W'(2'b11));
    check("deact.crd3", FLIT_W'(crd_out), FLIT_W'(3));
    for (int i = 0; i < 3; i++) begin
      step(1'b1, mk_flit('0), 1'b1);
      check("deact.nolcrdv", FLIT_W'(lcrdv), '0);
      check("deact.hold", FLIT_W'(link_state), FLIT_W'(2'b11));
    end
    check("deact.crd0", FLIT_W'(crd_out), '0);
    check("deact.noenq", FLIT_W'(flit_valid), '0);
    idle(1, 1'b1);
    check("deact.stop", FLIT_W'(link_state), '0);
    check("deact.ack0", FLIT_W'(laack), '0);

    // Overflow in STOP
    step(1'b1, mk_flit(OPC_COMP_ACK), 1'b0);
    check("ovf.set", FLIT_W'(ovf_err), FLIT_W'(1));
    check("ovf.novalid", FLIT_W'(flit_valid), '0);
    check("ovf.crd", FLIT_W'(crd_out), '0);
    idle(3, 1'b0);
    check("ovf.sticky", FLIT_W'(ovf_err), FLIT_W'(1));
    rst = 1'b1;
    idle(1, 1'b0);
    check("ovf.clear", FLIT_W'(ovf_err), '0);
    rst = 1'b0;

    // Reset mid-operation with two flits buffered
    lareq = 1'b1;
    idle(8, 1'b0);
    step(1'b1, mk_flit(rand_opc()), 1'b0);
    step(1'b1, mk_flit(rand_opc()), 1'b0);
    check("midrst.crd2", FLIT_W'(crd_out), FLIT_W'(2));
    rst = 1'b1;
    idle(1, 1'b0);
    check("midrst.state", FLIT_W'(link_state), '0);
    check("midrst.ack", FLIT_W'(laack), '0);
    check("midrst.lcrdv", FLIT_W'(lcrdv), '0);
    check("midrst.valid", FLIT_W'(flit_valid), '0);
    check("midrst.flit", flit_out, '0);
    check("midrst.crd", FLIT_W'(crd_out), '0);
    rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      idle(1, 1'b1);
      stale += int'(flit_valid);
    end
    check("midrst.stale", FLIT_W'(stale), '0);

    // Random traffic, back-pressure, credit returns and link toggling
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 31) == 0) lareq = ~lareq;
      rv   = (m_crd > 0) && ($urandom_range(0, 9) < 7);
      ropc = ($urandom_range(0, 7) == 0) ? '0 : rand_opc();
      rr   = $urandom_range(0, 3) != 0;
      step(rv, mk_flit(ropc), rr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
